// File: rtl/timer_bus_master.sv
// rtl/timer_bus_master.sv - load/store requests to a 32-bit peripheral bus, with split 64-bit access
// Build option: define HILO_RECHECK_EN for coherent hi/lo/hi double reads (retry up to RECHK_MAX).
module timer_bus_master #(
  parameter int RECHK_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sel,
  output logic [15:0] addr,
  output logic [2:0]  we,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  typedef enum logic [2:0] {IDLE, LO, HI, RECHK, RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Captured request fields
  logic        r_write;
  logic [1:0]  r_size;
  logic [15:0] r_addr;
  logic [63:0] r_wdata;
  logic [31:0] r_lo;

  // Registered bus and response outputs
  logic        r_sel;
  logic [15:0] r_addr_o;
  logic [2:0]  r_we;
  logic [31:0] r_wdata_o;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [63:0] r_rsp_rdata;

  logic        w_sel_nxt;
  logic [15:0] w_addr_nxt;
  logic [2:0]  w_we_nxt;
  logic [31:0] w_wdata_nxt;
  logic        w_rsp_valid_nxt;
  logic        w_rsp_err_nxt;
  logic [63:0] w_rsp_rdata_nxt;
  logic        w_misaligned;
  logic [15:0] w_addr_hi;

`ifdef HILO_RECHECK_EN
  localparam int LP_ATT_W = (RECHK_MAX < 2) ? 1 : $clog2(RECHK_MAX + 1);
  localparam logic [LP_ATT_W-1:0] LP_ATT_MAX = LP_ATT_W'(RECHK_MAX);
  logic [31:0]         r_hi;
  logic [LP_ATT_W-1:0] r_attempt;
  logic                w_retry;
`endif

  assign req_ready = rst_n && (r_state == IDLE);
  assign sel       = r_sel;
  assign addr      = r_addr_o;
  assign we        = r_we;
  assign wdata     = r_wdata_o;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign w_addr_hi = r_addr + 16'd4;

  // Natural alignment check on the incoming request
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      2'b11:   w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // Next state, next bus beat and response selection
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = 1'b0;
    w_addr_nxt      = 16'h0;
    w_we_nxt        = 3'b000;
    w_wdata_nxt     = 32'h0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
`ifdef HILO_RECHECK_EN
    w_retry         = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_misaligned) begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = 64'h0;
          end
`ifdef HILO_RECHECK_EN
          else if (req_size == 2'b11 && !req_write) begin
            // Coherent read starts with the high word
            w_state_nxt = HI;
            w_sel_nxt   = 1'b1;
            w_addr_nxt  = req_addr + 16'd4;
            w_we_nxt    = 3'b0_10;
          end
`endif
          else begin
            w_state_nxt = LO;
            w_sel_nxt   = 1'b1;
            w_addr_nxt  = req_addr;
            w_we_nxt    = {req_write, (req_size == 2'b11) ? 2'b10 : req_size};
            w_wdata_nxt = req_wdata[31:0];
          end
        end
      end
      LO: begin
        if (r_size == 2'b11) begin
          w_sel_nxt  = 1'b1;
          w_addr_nxt = w_addr_hi;
          w_we_nxt   = {r_write, 2'b10};
`ifdef HILO_RECHECK_EN
          if (r_write) begin
            w_state_nxt = HI;
            w_wdata_nxt = r_wdata[63:32];
          end else begin
            w_state_nxt = RECHK;
          end
`else
          w_state_nxt = HI;
          w_wdata_nxt = r_wdata[63:32];
`endif
        end else begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = {32'h0, rdata};
        end
      end
      HI: begin
`ifdef HILO_RECHECK_EN
        if (!r_write) begin
          w_state_nxt = LO;
          w_sel_nxt   = 1'b1;
          w_addr_nxt  = r_addr;
          w_we_nxt    = 3'b0_10;
        end else
`endif
        begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = {rdata, r_lo};
        end
      end
`ifdef HILO_RECHECK_EN
      RECHK: begin
        if (rdata == r_hi) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = {r_hi, r_lo};
        end else if (r_attempt == LP_ATT_MAX) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = {rdata, r_lo};
        end else begin
          // High word moved under us: re-read low against the new high
          w_retry     = 1'b1;
          w_state_nxt = LO;
          w_sel_nxt   = 1'b1;
          w_addr_nxt  = r_addr;
          w_we_nxt    = 3'b0_10;
        end
      end
`endif
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset clears the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_addr_o    <= 16'h0;
      r_we        <= 3'b000;
      r_wdata_o   <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 64'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_addr_o    <= w_addr_nxt;
      r_we        <= w_we_nxt;
      r_wdata_o   <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // Request capture and per-beat read data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 16'h0;
      r_wdata <= 64'h0;
      r_lo    <= 32'h0;
`ifdef HILO_RECHECK_EN
      r_hi      <= 32'h0;
      r_attempt <= '0;
`endif
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_write <= req_write;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
`ifdef HILO_RECHECK_EN
        r_attempt <= LP_ATT_W'(1);
`endif
      end
      if (r_state == LO) r_lo <= rdata;
`ifdef HILO_RECHECK_EN
      if (r_state == HI || w_retry) r_hi <= rdata;
      if (w_retry) r_attempt <= r_attempt + LP_ATT_W'(1);
`endif
    end
  end

endmodule

// File: doc/timer_bus_master.md
TIMER_BUS_MASTER -- requirements
Module: timer_bus_master

Interface
REQ-001 SHALL have parameter RECHK_MAX, default 3, maximum hi/lo/hi re-read attempts before error.
REQ-002 SHALL have ports, in order:
- clk  in  1  global clock, all state on rising edge.
- rst_n  in  1  global reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (64-bit).
- req_addr  in  16  byte address.
- req_wdata  in  64  store data (low bits used for sizes 00..10).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  64  load data.
- rsp_err  out  1  qualifies rsp_valid: misaligned or re-check exhausted.
- sel  out  1  peripheral select.
- addr  out  16  peripheral address.
- we  out  3  we[2] write strobe, we[1:0] size (00/01/10).
- wdata  out  32  peripheral write data.
- rdata  in  32  peripheral read data, combinational from sel/addr, 0 when sel=0.

Function
REQ-003 SHALL assert req_ready only in state IDLE; a request is accepted on a rising edge with req_valid & req_ready, and its fields are registered.
REQ-004 SHALL use states IDLE, LO, HI, RECHK, RESP; outputs are registered, and one bus beat occupies one cycle.
REQ-005 SHALL drive sel=0, we=0, addr=0, wdata=0 in IDLE and RESP.
REQ-006 SHALL treat a request as misaligned if size 01 with addr[0]!=0, size 10 with addr[1:0]!=0, or size 11 with addr[2:0]!=0; it then goes IDLE->RESP with no beat and rsp_err=1.
REQ-007 Sizes 00/01/10 SHALL do one beat in LO: sel=1, addr=req_addr, we={req_write,req_size}, wdata=req_wdata[31:0].
REQ-008 A double write SHALL do LO (addr, we=3'b1_10, wdata[31:0]) then HI (addr+4, wdata[63:32]).
REQ-009 A double read SHALL follow REQ-013/REQ-014 using we=3'b0_10.
REQ-010 Read data SHALL be captured from rdata at the rising edge ending each beat; single-beat loads return {32'h0, rdata}.
REQ-011 rsp_valid SHALL pulse for exactly the RESP cycle, then return to IDLE; latency from acceptance to rsp_valid is 2 cycles for a single beat, 3 for a double write.
REQ-012 rsp_rdata SHALL hold its value until the next response; rsp_err=0 for every non-error response.

Reset
REQ-015 While rst_n=0, all outputs SHALL be 0 and state IDLE, including reset asserted mid-beat; sel drops without waiting for a clock, and no response is issued for an aborted request.
REQ-016 After rst_n rises, req_ready SHALL be 1 on the first cycle.

Configuration
REQ-013 With HILO_RECHECK_EN defined, a double read SHALL do HI (addr+4) then LO (addr) then RECHK (addr+4). If RECHK data equals the first HI data, it responds with {hi, lo}; otherwise it repeats LO, RECHK using the new hi, up to RECHK_MAX total attempts. When attempts are exhausted it responds with rsp_err=1 and the last data.
REQ-014 Without HILO_RECHECK_EN, a double read SHALL do LO (addr) then HI (addr+4) and respond {hi, lo}, with latency 3 and no RECHK state.

Verification
REQ-017 Word write 0x0000 data 0x5555_5555 then word read 0x0000 -> one beat with we=3'b1_10 then we=3'b0_10; rsp_rdata=0x0000_0000_5555_5555; rsp_valid 2 cycles after each acceptance.
REQ-018 Double write 0x4000 data 0xFFFF_FFFF_AAAA_AAAA -> beats 0x4000/0xAAAA_AAAA then 0x4004/0xFFFF_FFFF; timer mtimecmp reads 0xFFFF_FFFF_AAAA_AAAA.
REQ-019 Timer counter forced to 0x0123_4567_89AB_CDEF, double read 0xBFF8 -> rsp_rdata=0x0123_4567_89AB_CDEF, rsp_err=0, in both macro builds.
REQ-020 HILO_RECHECK_EN, counter at 0x0000_0000_FFFF_FFFF free-running -> high word changes between beats; one retry, then coherent result 0x0000_0001_xxxx_xxxx with low word below 0x10.
REQ-021 Misaligned word read at 0x0002 -> no sel pulse, rsp_valid with rsp_err=1 one cycle after acceptance.
REQ-022 rst_n low during the HI beat of a double write -> sel=0 immediately, no rsp_valid, req_ready=1 on the first cycle after release.
